// File: rtl/full_adder.sv
// Two-stage pipelined full adder with a saturating carry event counter.
// Stage 1 captures the input bits and a valid flag; stage 2 forms the
// sum/carry from the captured bits and registers them. Every output comes
// straight from a flop. Reset is synchronous and active-low.
module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a,
  input  logic             b,
  input  logic             carry_in,
  output logic             sum,
  output logic             carry_out,
  output logic             valid,
  output logic [CNT_W-1:0] carry_cnt
);

  logic             r_a;
  logic             r_b;
  logic             r_cin;
  logic             r_vld1;

  logic             r_sum;
  logic             r_cout;
  logic             r_vld2;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum;
  logic             w_cout;
  logic             w_cnt_sat;
  logic             w_cnt_inc;

  // Stage 2 arithmetic, computed only from the stage-1 flops.
  always_comb begin
    w_sum  = r_a ^ r_b ^ r_cin;
    w_cout = (r_a & r_b) | (r_a & r_cin) | (r_b & r_cin);
  end

  // Count a result only when it is being registered as valid with a carry,
  // and hold once every counter bit is set so the count never wraps.
  always_comb begin
    w_cnt_sat = &r_cnt;
    w_cnt_inc = r_vld1 & w_cout & ~w_cnt_sat;
  end

  // Stage 1: capture inputs; valid rises on every non-reset edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_a    <= 1'b0;
      r_b    <= 1'b0;
      r_cin  <= 1'b0;
      r_vld1 <= 1'b0;
    end else begin
      r_a    <= a;
      r_b    <= b;
      r_cin  <= carry_in;
      r_vld1 <= 1'b1;
    end
  end

  // Stage 2: register result and valid; reset flushes any in-flight result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sum  <= 1'b0;
      r_cout <= 1'b0;
      r_vld2 <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_vld2 <= r_vld1;
    end
  end

  // Carry event counter; reset wins over a same-edge increment.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign valid     = r_vld2;
  assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a cycle model built from the
// arithmetic rules (2-cycle latency, a+b+carry_in, saturating count) checked
// every cycle, plus directed literal expectations that pin the model.
module tb_full_adder;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rstn;
  logic             a;
  logic             b;
  logic             carry_in;
  logic             sum;
  logic             carry_out;
  logic             valid;
  logic [CNT_W-1:0] carry_cnt;

  int n_checks;
  int n_pass;

  full_adder #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sum      (sum),
    .carry_out(carry_out),
    .valid    (valid),
    .carry_cnt(carry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: results appear two edges after sampling; a reset edge
  // clears everything and inputs captured under reset count as zero.
  bit       m_init;
  bit       m_prev_run;
  int       m_prev_total;
  bit       m_valid;
  int       m_res;
  int       m_cnt;

  always @(posedge clk) begin
    if (rstn === 1'b0) begin
      m_init       = 1'b1;
      m_valid      = 1'b0;
      m_res        = 0;
      m_cnt        = 0;
      m_prev_run   = 1'b0;
      m_prev_total = 0;
    end else if (m_init) begin
      m_valid = m_prev_run;
      m_res   = m_prev_total;
      if (m_valid && m_res >= 2 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_prev_run   = 1'b1;
      m_prev_total = int'(a) + int'(b) + int'(carry_in);
    end
  end

  // Compare the DUT against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (m_init) begin
      chk("model_sum",   32'(sum),       32'(m_res % 2));
      chk("model_cout",  32'(carry_out), 32'(m_res / 2));
      chk("model_valid", 32'(valid),     32'(m_valid));
      chk("model_cnt",   32'(carry_cnt), 32'(m_cnt));
    end
  end

  task automatic step(input logic r, input logic ia, input logic ib, input logic ic);
    rstn     = r;
    a        = ia;
    b        = ib;
    carry_in = ic;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sum_tab;
  logic [7:0] exp_cout_tab;
  logic [2:0] v;

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    exp_sum_tab  = 8'b1001_0110;
    exp_cout_tab = 8'b1110_1000;
    rstn = 1'b0; a = 1'b0; b = 1'b0; carry_in = 1'b0;

    // Reset held for two edges.
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_sum",   32'(sum),       32'd0);
    chk("rst_cout",  32'(carry_out), 32'd0);
    chk("rst_valid", 32'(valid),     32'd0);
    chk("rst_cnt",   32'(carry_cnt), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // All eight input combinations back-to-back.
    for (int k = 0; k < 10; k++) begin
      v = (k < 8) ? 3'(k) : 3'd0;
      step(1'b1, v[2], v[1], v[0]);
      if (k == 0) chk("first_edge_valid", 32'(valid), 32'd0);
      if (k >= 1 && k <= 8) begin
        chk($sformatf("tt_sum_%0d", k - 1),  32'(sum),       32'(exp_sum_tab[k-1]));
        chk($sformatf("tt_cout_%0d", k - 1), 32'(carry_out), 32'(exp_cout_tab[k-1]));
        chk($sformatf("tt_valid_%0d", k - 1), 32'(valid),    32'd1);
      end
      if (k == 8) chk("tt_cnt", 32'(carry_cnt), 32'd4);
    end

    // Saturation with a=b=1, carry_in=0.
    for (int k = 0; k < 300; k++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_cnt",  32'(carry_cnt), 32'd255);
    chk("sat_sum",  32'(sum),       32'd0);
    chk("sat_cout", 32'(carry_out), 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("sat_hold", 32'(carry_cnt), 32'd255);

    // Mid-stream reset discards both in-flight results.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("mid_rst_sum",   32'(sum),       32'd0);
    chk("mid_rst_cout",  32'(carry_out), 32'd0);
    chk("mid_rst_valid", 32'(valid),     32'd0);
    chk("mid_rst_cnt",   32'(carry_cnt), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("post_rst_valid", 32'(valid),     32'd0);
    chk("post_rst_cnt",   32'(carry_cnt), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_res_valid", 32'(valid),     32'd1);
    chk("post_rst_res_sum",   32'(sum),       32'd1);
    chk("post_rst_res_cout",  32'(carry_out), 32'd1);
    chk("post_rst_res_cnt",   32'(carry_cnt), 32'd1);

    // Random traffic with occasional reset pulses.
    for (int k = 0; k < 1000; k++) begin
      v = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, v[2], v[1], v[0]);
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
